// File: rtl/prog_loader_pkg.sv
// Shared types and sizes for the program-memory loader.
// State encoding, word geometry and the default frame marker.
package brus16_loader_pkg;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;

   localparam logic [7:0]  SYNC_BYTE_DFLT = 8'hA5;
   localparam logic [15:0] MAX_LEN        = 16'(2 ** ADDR_W);

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CHK
   } state_e;

   // A zero length field stands for a full memory image.
   function automatic logic [ADDR_W:0] decode_len(logic [15:0] raw);
      if (raw == 16'h0000)
         decode_len = (ADDR_W + 1)'(2 ** ADDR_W);
      else
         decode_len = raw[ADDR_W:0];
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, program memory write port out.
// The loader sits on the slave side.
interface prog_loader_if;
   import brus16_loader_pkg::*;

   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_ad;
   logic [DATA_W-1:0] mem_din;

   modport slave (
      input  rx_data, rx_valid,
      output mem_we, mem_ad, mem_din
   );

   modport master (
      output rx_data, rx_valid,
      input  mem_we, mem_ad, mem_din
   );

endinterface

// File: rtl/prog_loader_timer.sv
// Inter-byte watchdog: reloads on every byte, fires after CYC idle clocks.
module loader_timer #(
   parameter int CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic reload,
   output logic expire
);

   localparam int W = $clog2(CYC + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en || reload)
         cnt_d = W'(CYC);
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= W'(CYC);
      else
         cnt_q <= cnt_d;
   end

   // A byte in the expiring cycle wins over the timeout.
   assign expire = en && !reload && (cnt_q == W'(1));

endmodule

// File: rtl/prog_loader.sv
// Framed byte stream -> 8K x 16 program memory writer, holds CPU until loaded.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
   import brus16_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DFLT,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic         clk,
   input  logic         reset,
   prog_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         done,
   output logic         err
);

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] ad_q, ad_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [7:0]        hi_q, hi_d;
   logic [7:0]        chk_q, chk_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              last_q, last_d;
   logic              expire;

   loader_timer #(.CYC(TIMEOUT_CYC)) u_timer (
      .clk    (clk),
      .rst_n  (reset),
      .en     (state_q != IDLE),
      .reload (bus.rx_valid),
      .expire (expire)
   );

   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      ad_d    = ad_q;
      din_d   = din_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = 1'b0;
      hi_d    = hi_q;
      chk_d   = chk_q;
      len_d   = len_q;
      last_d  = last_q;

      // Retire the write issued last cycle.
      if (we_q) begin
         if (!last_q)
            ad_d = ad_q + ADDR_W'(1);
`ifndef PROG_LOADER_CHECKSUM_EN
         else begin
            done_d = 1'b1;
            hold_d = 1'b0;
         end
`endif
      end

      if (expire) begin
         err_d   = 1'b1;
         state_d = IDLE;
      end else if (bus.rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (bus.rx_data == SYNC_BYTE) begin
                  state_d = LEN_HI;
                  hold_d  = 1'b1;
                  done_d  = 1'b0;
                  ad_d    = '0;
                  chk_d   = '0;
                  last_d  = 1'b0;
               end
            end
            LEN_HI: begin
               hi_d    = bus.rx_data;
               state_d = LEN_LO;
            end
            LEN_LO: begin
               if ({hi_q, bus.rx_data} > MAX_LEN) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  len_d   = decode_len({hi_q, bus.rx_data});
                  state_d = DATA_HI;
               end
            end
            DATA_HI: begin
               hi_d    = bus.rx_data;
               chk_d   = chk_q ^ bus.rx_data;
               state_d = DATA_LO;
            end
            DATA_LO: begin
               we_d    = 1'b1;
               din_d   = {hi_q, bus.rx_data};
               chk_d   = chk_q ^ bus.rx_data;
               last_d  = ({1'b0, ad_q} == len_q - (ADDR_W + 1)'(1));
`ifdef PROG_LOADER_CHECKSUM_EN
               state_d = last_d ? CHK : DATA_HI;
`else
               state_d = last_d ? IDLE : DATA_HI;
`endif
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK: begin
               state_d = IDLE;
               if (bus.rx_data == chk_q) begin
                  done_d = 1'b1;
                  hold_d = 1'b0;
               end else begin
                  err_d  = 1'b1;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         ad_q    <= '0;
         din_q   <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         hi_q    <= '0;
         chk_q   <= '0;
         len_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         ad_q    <= ad_d;
         din_q   <= din_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
         hi_q    <= hi_d;
         chk_q   <= chk_d;
         len_q   <= len_d;
         last_q  <= last_d;
      end
   end

   assign bus.mem_we  = we_q;
   assign bus.mem_ad  = ad_q;
   assign bus.mem_din = din_q;
   assign cpu_hold    = hold_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule
